// File: rtl/sd4_mac_pkg.sv
// ============================================================================
// Module      : sd4_mac_pkg
// Description : Shared state encoding and default widths for the SD4 MAC path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sd4_mac_pkg;

   localparam int c_SUM_W = 20;
   localparam int c_ACC_W = 32;
   localparam int c_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sd4_sat_add.sv
// ============================================================================
// Module      : sd4_sat_add
// Description : Combinational signed add of a wide accumulator and a narrow
//               term, clamped to the accumulator range with a saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd4_sat_add #(
   parameter int ACC_W = 32,
   parameter int SUM_W = 20
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [SUM_W-1:0] sum_i,
   output logic [ACC_W-1:0] res_o,
   output logic             sat_o
);

   logic [ACC_W:0] w_a;
   logic [ACC_W:0] w_b;
   logic [ACC_W:0] w_sum;

   assign w_a   = {acc_i[ACC_W-1], acc_i};
   assign w_b   = {{(ACC_W+1-SUM_W){sum_i[SUM_W-1]}}, sum_i};
   assign w_sum = w_a + w_b;

   // The guard bit disagreeing with the result sign means the true sum left
   // the ACC_W range; the guard bit then holds the true sign.
   assign sat_o = w_sum[ACC_W] ^ w_sum[ACC_W-1];

   always_comb begin
      res_o = w_sum[ACC_W-1:0];
      if (sat_o) begin
         res_o = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                              : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end

endmodule

`default_nettype wire

// File: rtl/sd4_accumulator.sv
// ============================================================================
// Module      : sd4_accumulator
// Description : Valid/ready accumulator of signed dot-product terms with
//               saturation, term counting and a held result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sd4_accumulator
   import sd4_mac_pkg::*;
#(
   parameter int SUM_W = c_SUM_W,
   parameter int ACC_W = c_ACC_W,
   parameter int CNT_W = c_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SUM_W-1:0] sum_in,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] term_cnt,
   output logic             ovf
);

   state_t             r_state_q;
   state_t             w_state_d;
   logic [ACC_W-1:0]   r_acc_q;
   logic [ACC_W-1:0]   w_acc_d;
   logic [CNT_W-1:0]   r_cnt_q;
   logic [CNT_W-1:0]   w_cnt_d;
   logic               r_ovf_q;
   logic               w_ovf_d;

   logic               w_in_xfer;
   logic               w_out_xfer;
   logic [ACC_W-1:0]   w_sum_sext;
   logic [ACC_W-1:0]   w_sat_sum;
   logic               w_sat;

   assign in_ready   = (r_state_q != HOLD) && !rst;
   assign out_valid  = (r_state_q == HOLD);
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;
   assign w_sum_sext = {{(ACC_W-SUM_W){sum_in[SUM_W-1]}}, sum_in};

   assign acc_out  = r_acc_q;
   assign term_cnt = r_cnt_q;
   assign ovf      = r_ovf_q;

   sd4_sat_add #(
      .ACC_W (ACC_W),
      .SUM_W (SUM_W)
   ) u_sat_add (
      .acc_i (r_acc_q),
      .sum_i (sum_in),
      .res_o (w_sat_sum),
      .sat_o (w_sat)
   );

   always_comb begin
      w_state_d = r_state_q;
      w_acc_d   = r_acc_q;
      w_cnt_d   = r_cnt_q;
      w_ovf_d   = r_ovf_q;
      unique case (r_state_q)
         IDLE: begin
            if (w_in_xfer) begin
               w_acc_d   = w_sum_sext;
               w_cnt_d   = CNT_W'(1);
               w_ovf_d   = 1'b0;
               w_state_d = in_last ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (w_in_xfer) begin
               w_acc_d = w_sat_sum;
               w_ovf_d = r_ovf_q | w_sat;
               if (r_cnt_q != {CNT_W{1'b1}}) begin
                  w_cnt_d = r_cnt_q + CNT_W'(1);
               end
               if (in_last) begin
                  w_state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (w_out_xfer) begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= IDLE;
         r_acc_q   <= '0;
         r_cnt_q   <= '0;
         r_ovf_q   <= 1'b0;
      end else begin
         r_state_q <= w_state_d;
         r_acc_q   <= w_acc_d;
         r_cnt_q   <= w_cnt_d;
         r_ovf_q   <= w_ovf_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sd4_accumulator.sv
// ============================================================================
// Module      : tb_sd4_accumulator
// Description : Scoreboard bench for sd4_accumulator at ACC_W=32 and ACC_W=22.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sd4_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [19:0] sum_in;
   logic        in_last;
   logic        out_ready;

   logic        in_ready,   in_ready22;
   logic        out_valid,  out_valid22;
   logic [31:0] acc_out;
   logic [21:0] acc_out22;
   logic [7:0]  term_cnt,   term_cnt22;
   logic        ovf,        ovf22;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] acc32;
      logic [21:0] acc22;
      logic [7:0]  cnt;
      logic        ovf32;
      logic        ovf22;
   } exp_t;

   exp_t   sb[$];
   longint m_acc32, m_acc22;
   int     m_cnt;
   bit     m_ovf32, m_ovf22;
   bit     m_first = 1'b1;

   always #5 clk = ~clk;

   sd4_accumulator #(.SUM_W(20), .ACC_W(32), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sum_in(sum_in), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf)
   );

   sd4_accumulator #(.SUM_W(20), .ACC_W(22), .CNT_W(8)) u_dut22 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready22),
      .sum_in(sum_in), .in_last(in_last), .out_valid(out_valid22),
      .out_ready(out_ready), .acc_out(acc_out22), .term_cnt(term_cnt22), .ovf(ovf22)
   );

   function automatic longint sat_add(input longint a, input longint b,
                                      input int w, output bit s);
      longint mx, mn, r;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -(longint'(1) <<< (w - 1));
      r  = a + b;
      s  = 1'b0;
      if (r > mx) begin r = mx; s = 1'b1; end
      if (r < mn) begin r = mn; s = 1'b1; end
      return r;
   endfunction

   task automatic model_term(input int val, input bit last);
      bit   s;
      exp_t e;
      if (m_first) begin
         m_acc32 = val; m_acc22 = val; m_cnt = 1;
         m_ovf32 = 1'b0; m_ovf22 = 1'b0; m_first = 1'b0;
      end else begin
         m_acc32 = sat_add(m_acc32, val, 32, s); m_ovf32 |= s;
         m_acc22 = sat_add(m_acc22, val, 22, s); m_ovf22 |= s;
         if (m_cnt < 255) m_cnt++;
      end
      if (last) begin
         e.acc32 = m_acc32[31:0];
         e.acc22 = m_acc22[21:0];
         e.cnt   = m_cnt[7:0];
         e.ovf32 = m_ovf32;
         e.ovf22 = m_ovf22;
         sb.push_back(e);
         m_first = 1'b1;
      end
   endtask

   // Entered and left on a falling edge.
   task automatic send_term(input int val, input bit last);
      int guard = 0;
      in_valid = 1'b1;
      sum_in   = val[19:0];
      in_last  = last;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
      end else begin
         @(posedge clk);
         model_term(val, last);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic collect(input int hold_cycles, input bit chk22);
      exp_t e;
      int   guard = 0;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL latency: out_valid=%0b required 1", out_valid);
         while (out_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
         end
      end
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL scoreboard_empty: size=0 required >0");
         return;
      end
      e = sb.pop_front();
      n_checks++;
      if (acc_out !== e.acc32) begin
         n_fail++; $display("FAIL acc_out: got %0d required %0d", $signed(acc_out), $signed(e.acc32));
      end
      n_checks++;
      if (term_cnt !== e.cnt) begin
         n_fail++; $display("FAIL term_cnt: got %0d required %0d", term_cnt, e.cnt);
      end
      n_checks++;
      if (ovf !== e.ovf32) begin
         n_fail++; $display("FAIL ovf: got %0b required %0b", ovf, e.ovf32);
      end
      if (chk22) begin
         n_checks++;
         if (acc_out22 !== e.acc22 || ovf22 !== e.ovf22 || term_cnt22 !== e.cnt) begin
            n_fail++;
            $display("FAIL acc22: got acc=%0d ovf=%0b cnt=%0d required acc=%0d ovf=%0b cnt=%0d",
                     $signed(acc_out22), ovf22, term_cnt22, $signed(e.acc22), e.ovf22, e.cnt);
         end
      end
      // Offer a term during the hold; it must be ignored.
      for (int i = 0; i < hold_cycles; i++) begin
         in_valid = 1'b1;
         sum_in   = 20'h0004D;
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || acc_out !== e.acc32 || term_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL hold_stable: ov=%0b ir=%0b acc=%0d cnt=%0d required ov=1 ir=0 acc=%0d cnt=%0d",
                     out_valid, in_ready, $signed(acc_out), term_cnt, $signed(e.acc32), e.cnt);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; sum_in = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== 32'd0 || term_cnt !== 8'd0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ir=%0b ov=%0b acc=%0d cnt=%0d ovf=%0b required 0 0 0 0 0",
                  in_ready, out_valid, acc_out, term_cnt, ovf);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_release: in_ready=%0b required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      send_term(100, 1'b0);
      send_term(-30, 1'b0);
      send_term(7, 1'b1);
      collect(0, 1'b1);
   endtask

   task automatic test_single_hold();
      send_term(-5, 1'b1);
      collect(4, 1'b1);
   endtask

   task automatic test_toggle();
      send_term(10, 1'b0);
      sum_in = 20'd999; @(negedge clk);
      send_term(20, 1'b0);
      sum_in = 20'd555; @(negedge clk);
      send_term(30, 1'b1);
      collect(0, 1'b1);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) send_term(524287, i == 4);
      collect(0, 1'b1);
      for (int i = 0; i < 5; i++) send_term(-524288, i == 4);
      collect(0, 1'b1);
      // Continues from the clamped value with ovf sticky.
      for (int i = 0; i < 5; i++) send_term(524287, 1'b0);
      send_term(-1, 1'b1);
      collect(0, 1'b1);
   endtask

   task automatic pulse_rst_check(input string name);
      rst = 1'b1; in_valid = 1'b1; sum_in = 20'd1000; in_last = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || acc_out !== 32'd0 || term_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL %s: ov=%0b ir=%0b acc=%0d cnt=%0d required 0 1 0 0",
                  name, out_valid, in_ready, acc_out, term_cnt);
      end
      m_first = 1'b1;
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_rst_mid();
      send_term(50, 1'b0);
      send_term(60, 1'b0);
      pulse_rst_check("rst_accum");
      send_term(3, 1'b0);
      send_term(4, 1'b1);
      collect(0, 1'b1);
      send_term(9, 1'b1);
      pulse_rst_check("rst_hold");
      send_term(5, 1'b1);
      collect(0, 1'b1);
   endtask

   task automatic test_cnt_sat();
      for (int i = 0; i < 300; i++) send_term(1, i == 299);
      collect(0, 1'b1);
   endtask

   task automatic test_back_to_back();
      send_term(-7, 1'b1);
      collect(0, 1'b1);
      send_term(1234, 1'b0);
      send_term(-234, 1'b1);
      collect(1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_hold();
      test_toggle();
      test_saturation();
      test_rst_mid();
      test_cnt_sat();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
